// File: rtl/aud_pkg.sv
// Shared widths and FSM state encoding for the I2S audio recorder.
package aud_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int ADDR_W    = 20;
  localparam int BIT_CNT_W = $clog2(SAMPLE_W);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LRC,
    SHIFT,
    WRITE,
    PAUSE
  } aud_state_t;
endpackage

// File: rtl/i2s_recorder.sv
// Captures the left-channel I2S sample of each frame and streams it to
// sequential SRAM words, with start/pause/resume/stop control.
module i2s_recorder
  import aud_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lrc,
  input  logic                i_data,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_wr,
  output logic                o_busy,
  output logic                o_full
);

  aud_state_t            r_state;
  aud_state_t            w_state_next;
  logic                  r_lrc_d;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [SAMPLE_W-1:0]   r_shift;
  logic [SAMPLE_W-1:0]   r_data;
  logic [ADDR_W-1:0]     r_address;
  logic                  r_full;

  logic                  w_frame_start;
  logic                  w_last_bit;
  logic                  w_at_max;
  logic [SAMPLE_W-1:0]   w_shift_in;

  // Falling LRC marks the first (delay) slot of the left channel.
  assign w_frame_start = !i_lrc && r_lrc_d;
  assign w_last_bit    = (r_bit_cnt == BIT_CNT_W'(SAMPLE_W - 1));
  assign w_at_max      = (r_address == MAX_ADDR);
  assign w_shift_in    = {r_shift[SAMPLE_W-2:0], i_data};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) w_state_next = WAIT_LRC;
      end
      WAIT_LRC: begin
        if (i_stop)              w_state_next = IDLE;
        else if (i_pause)        w_state_next = PAUSE;
        else if (w_frame_start)  w_state_next = SHIFT;
      end
      SHIFT: begin
        if (i_stop)              w_state_next = IDLE;
        else if (i_pause)        w_state_next = PAUSE;
        else if (w_last_bit)     w_state_next = WRITE;
      end
      WRITE: begin
        // The strobe cycle always completes; control pulses only pick the exit.
        if (w_at_max || i_stop)  w_state_next = IDLE;
        else if (i_pause)        w_state_next = PAUSE;
        else                     w_state_next = WAIT_LRC;
      end
      PAUSE: begin
        if (i_stop)              w_state_next = IDLE;
        else if (i_start)        w_state_next = WAIT_LRC;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_lrc_d   <= 1'b1;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_address <= '0;
      r_full    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lrc_d <= i_lrc;
      case (r_state)
        IDLE: begin
          if (w_state_next == WAIT_LRC) begin
            r_address <= '0;
            r_full    <= 1'b0;
          end
        end
        WAIT_LRC: begin
          r_bit_cnt <= '0;
        end
        SHIFT: begin
          r_shift   <= w_shift_in;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_state_next == WRITE) r_data <= w_shift_in;
        end
        WRITE: begin
          if (w_at_max) r_full    <= 1'b1;
          else          r_address <= r_address + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_address = r_address;
  assign o_data    = r_data;
  assign o_wr      = (r_state == WRITE);
  assign o_busy    = (r_state != IDLE);
  assign o_full    = r_full;

endmodule

// File: tb/tb_i2s_recorder.sv
// Self-checking bench: I2S frame generator, frame-level recorder model and
// per-cycle comparison for a full-size and a 4-word recorder.
module tb_i2s_recorder;
  localparam int HALF  = 24;
  localparam int FRAME = 2 * HALF;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n, i_lrc, i_data, i_start, i_pause, i_stop;
  logic [19:0] addr0, addr3;
  logic [15:0] data0, data3;
  logic wr0, busy0, full0, wr3, busy3, full3;

  always #5 clk = ~clk;

  i2s_recorder u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(i_lrc), .i_data(i_data),
    .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_address(addr0), .o_data(data0), .o_wr(wr0), .o_busy(busy0), .o_full(full0)
  );

  i2s_recorder #(.MAX_ADDR(20'd3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(i_lrc), .i_data(i_data),
    .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_address(addr3), .o_data(data3), .o_wr(wr3), .o_busy(busy3), .o_full(full3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Recorder model: mode plus "how far into the current left sample" counter.
  typedef struct {
    int          mode;
    int          cap;
    bit          wr;
    logic [15:0] sh;
    logic [15:0] data;
    logic [19:0] addr;
    bit          full;
    bit          lrc_prev;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = M_IDLE; m.cap = 0; m.wr = 0; m.sh = '0; m.data = '0;
    m.addr = '0; m.full = 0; m.lrc_prev = 1;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [19:0] maxa,
                                 bit st, bit pa, bit sp, bit lrc, bit d);
    bit fs;
    fs = !lrc && m.lrc_prev;
    m.lrc_prev = lrc;
    if (m.wr) begin
      m.wr = 0;
      if (m.addr == maxa) begin m.full = 1; m.mode = M_IDLE; end
      else m.addr = m.addr + 1;
      if (sp) m.mode = M_IDLE;
      else if (pa && m.mode != M_IDLE) m.mode = M_PAUSE;
    end else if (m.cap > 0) begin
      if (sp) begin m.mode = M_IDLE; m.cap = 0; end
      else if (pa) begin m.mode = M_PAUSE; m.cap = 0; end
      else begin
        m.sh = {m.sh[14:0], d};
        if (m.cap == 16) begin m.cap = 0; m.wr = 1; m.data = m.sh; end
        else m.cap++;
      end
    end else begin
      case (m.mode)
        M_IDLE:  if (st && !sp) begin m.mode = M_RUN; m.addr = '0; m.full = 0; end
        M_PAUSE: if (sp) m.mode = M_IDLE; else if (st) m.mode = M_RUN;
        default: if (sp) m.mode = M_IDLE;
                 else if (pa) m.mode = M_PAUSE;
                 else if (fs) m.cap = 1;
      endcase
    end
    return m;
  endfunction

  typedef struct { logic [19:0] a; logic [15:0] d; int p; } wr_t;
  wr_t wlog0[$];
  wr_t wlog3[$];
  mdl_t m0, m3;

  // Frame generator state
  int p = 30;
  int cyc = 0;
  bit rand_mode = 0;
  logic [15:0] cur_left = '0, cur_right = 16'h1234;
  logic [15:0] left_q[$];
  bit f_start = 0, f_pause = 0, f_stop = 0;

  task automatic cmp_inst(string tag, mdl_t m, logic [19:0] a, logic [15:0] d,
                          logic w, logic b, logic f);
    chk({tag, "_wr"}, 32'(w), 32'(m.wr));
    chk({tag, "_busy"}, 32'(b), 32'(m.mode != M_IDLE));
    chk({tag, "_full"}, 32'(f), 32'(m.full));
    chk({tag, "_addr"}, 32'(a), 32'(m.addr));
    if (m.wr) chk({tag, "_data"}, 32'(d), 32'(m.data));
  endtask

  initial begin
    m0 = mreset();
    m3 = mreset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m0 = mreset();
        m3 = mreset();
      end else begin
        m0 = mstep(m0, 20'hFFFFF, i_start, i_pause, i_stop, i_lrc, i_data);
        m3 = mstep(m3, 20'd3,     i_start, i_pause, i_stop, i_lrc, i_data);
      end
      #1;
      cmp_inst("dut", m0, addr0, data0, wr0, busy0, full0);
      cmp_inst("dut3", m3, addr3, data3, wr3, busy3, full3);
      if (wr0 === 1'b1) begin
        wlog0.push_back('{addr0, data0, p});
        $display("WR dut  addr=%05h data=%04h pos=%0d", addr0, data0, p);
      end
      if (wr3 === 1'b1) begin
        wlog3.push_back('{addr3, data3, p});
        $display("WR dut3 addr=%05h data=%04h pos=%0d", addr3, data3, p);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    p = (p == FRAME - 1) ? 0 : p + 1;
    if (p == 0) cur_left = (left_q.size() > 0) ? left_q.pop_front() : 16'($urandom);
    if (p == HALF) cur_right = rand_mode ? 16'($urandom) : 16'h1234;
    i_lrc = (p >= HALF);
    if (p >= 1 && p <= 16) i_data = cur_left[16 - p];
    else if (p >= HALF + 1 && p <= HALF + 16) i_data = cur_right[HALF + 16 - p];
    else i_data = 1'($urandom);
    i_start = f_start; i_pause = f_pause; i_stop = f_stop;
    f_start = 0; f_pause = 0; f_stop = 0;
    cyc++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_p(int k);
    int n = 0;
    do begin tick(); n++; end while (p != k && n < 200);
    chk("wait_pos_timeout", 32'(p), 32'(k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; i_lrc = 1; i_data = 0; i_start = 0; i_pause = 0; i_stop = 0;
    ticks(3);
    chk("rst_addr", 32'(addr0), 32'h0);
    chk("rst_data", 32'(data0), 32'h0);
    chk("rst_wr",   32'(wr0),   32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_full", 32'(full0), 32'h0);
    rst_n = 1;

    // Single sample A5C3
    wait_p(40); f_start = 1; left_q.push_back(16'hA5C3);
    wait_p(20);
    chk("t1_count", 32'(wlog0.size()), 32'd1);
    if (wlog0.size() > 0) begin
      chk("t1_data", 32'(wlog0[0].d), 32'hA5C3);
      chk("t1_addr", 32'(wlog0[0].a), 32'h0);
      chk("t1_latency_pos", 32'(wlog0[0].p), 32'd16);
    end
    chk("t1_addr_after", 32'(addr0), 32'd1);
    wlog0.delete(); wlog3.delete();

    // Three frames, fresh start
    wait_p(40); f_stop = 1;
    wait_p(44); f_start = 1;
    left_q.push_back(16'h0001); left_q.push_back(16'h8000); left_q.push_back(16'hFFFF);
    for (int i = 0; i < 3; i++) wait_p(20);
    chk("t2_count", 32'(wlog0.size()), 32'd3);
    if (wlog0.size() == 3) begin
      chk("t2_a0", 32'(wlog0[0].a), 32'd0); chk("t2_d0", 32'(wlog0[0].d), 32'h0001);
      chk("t2_a1", 32'(wlog0[1].a), 32'd1); chk("t2_d1", 32'(wlog0[1].d), 32'h8000);
      chk("t2_a2", 32'(wlog0[2].a), 32'd2); chk("t2_d2", 32'(wlog0[2].d), 32'hFFFF);
    end
    wlog0.delete(); wlog3.delete();

    // Pause mid-sample, resume
    wait_p(7); f_pause = 1;
    wait_p(40);
    chk("t3_paused_busy", 32'(busy0), 32'd1);
    chk("t3_partial_count", 32'(wlog0.size()), 32'd0);
    f_start = 1; left_q.push_back(16'hBEEF);
    wait_p(20);
    chk("t3_count", 32'(wlog0.size()), 32'd1);
    if (wlog0.size() > 0) begin
      chk("t3_addr", 32'(wlog0[0].a), 32'd3);
      chk("t3_data", 32'(wlog0[0].d), 32'hBEEF);
    end
    chk("t3_dut3_full", 32'(full3), 32'd1);
    wlog0.delete(); wlog3.delete();

    // Fill the 4-word recorder with five frames
    wait_p(40); f_stop = 1;
    wait_p(44); f_start = 1;
    for (int i = 1; i <= 5; i++) left_q.push_back(16'(i * 16'h1111));
    for (int i = 0; i < 5; i++) wait_p(20);
    chk("t4_count3", 32'(wlog3.size()), 32'd4);
    for (int i = 0; i < wlog3.size() && i < 4; i++) begin
      chk("t4_addr3", 32'(wlog3[i].a), 32'(i));
      chk("t4_data3", 32'(wlog3[i].d), 32'((i + 1) * 16'h1111));
    end
    chk("t4_full3", 32'(full3), 32'd1);
    chk("t4_busy3", 32'(busy3), 32'd0);
    chk("t4_addr3_hold", 32'(addr3), 32'd3);
    chk("t4_count0", 32'(wlog0.size()), 32'd5);
    wait_p(40); f_start = 1;
    ticks(2);
    chk("t4_full3_clr", 32'(full3), 32'd0);
    chk("t4_addr3_clr", 32'(addr3), 32'd0);
    chk("t4_busy3_run", 32'(busy3), 32'd1);
    wlog0.delete(); wlog3.delete();

    // Stop and pause together mid-shift
    wait_p(4); f_stop = 1; f_pause = 1;
    ticks(2);
    chk("t5_busy", 32'(busy0), 32'd0);
    chk("t5_busy3", 32'(busy3), 32'd0);
    wait_p(20);
    chk("t5_count", 32'(wlog0.size()), 32'd0);

    // Reset just before the write
    wait_p(40); f_start = 1;
    wait_p(20);
    chk("t6_addr_before", 32'(addr0), 32'd1);
    wlog0.delete(); wlog3.delete();
    wait_p(15);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_wr",   32'(wr0),   32'd0);
    chk("t6_rst_busy", 32'(busy0), 32'd0);
    chk("t6_rst_addr", 32'(addr0), 32'd0);
    chk("t6_rst_data", 32'(data0), 32'd0);
    chk("t6_rst_full", 32'(full0), 32'd0);
    ticks(3);
    rst_n = 1;
    wait_p(20); wait_p(20);
    chk("t6_count", 32'(wlog0.size()), 32'd0);

    // Randomized control pulses and samples against the model
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) f_start = 1;
      else if (r == 3) f_pause = 1;
      else if (r == 4 && $urandom_range(0, 3) == 0) f_stop = 1;
      tick();
    end
    ticks(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2s_recorder.md
I2S_RECORDER -- requirements
Module: i2s_recorder

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 20'hFFFFF, meaning last writable SRAM word address.
REQ-002 SHALL have port i_clk  input  1  audio bit clock (codec BCLK); all logic on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_lrc  input  1  codec ADCLRCK; low = left channel.
REQ-005 SHALL have port i_data  input  1  codec ADCDAT serial bit.
REQ-006 SHALL have port i_start  input  1  one-cycle pulse; begin or resume recording.
REQ-007 SHALL have port i_pause  input  1  one-cycle pulse; suspend recording.
REQ-008 SHALL have port i_stop  input  1  one-cycle pulse; end recording.
REQ-009 SHALL have port o_address  output  20  SRAM word address of current/next write.
REQ-010 SHALL have port o_data  output  16  captured left-channel sample, MSB first on the wire.
REQ-011 SHALL have port o_wr  output  1  one-cycle write strobe; o_address/o_data valid while high.
REQ-012 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port o_full  output  1  high after write to MAX_ADDR; cleared by next i_start from IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT_LRC, SHIFT, WRITE, PAUSE.
REQ-015 SHALL register i_lrc into lrc_d every cycle; left frame start = (i_lrc==0 && lrc_d==1).
REQ-016 IDLE + i_start: o_address<=0, o_full<=0, go WAIT_LRC.
REQ-017 WAIT_LRC: on left frame start, treat that cycle as the I2S one-bit delay slot (bit not captured), go SHIFT with bit counter 0.
REQ-018 SHIFT: shift i_data into sample register on each of the next 16 cycles (MSB first); after 16th bit go WRITE.
REQ-019 WRITE: o_data = captured sample, o_wr=1 for exactly this one cycle at current o_address; latency from LSB sample to o_wr = 1 cycle.
REQ-020 On leaving WRITE: if o_address==MAX_ADDR set o_full, go IDLE, address held; else o_address+1, go WAIT_LRC.
REQ-021 Right-channel data (i_lrc high) and bits 17+ of any frame SHALL be ignored.
REQ-022 i_pause in WAIT_LRC/SHIFT/WRITE: go PAUSE; partial sample discarded, no o_wr; a write in progress in WRITE completes that cycle and address advances per REQ-020.
REQ-023 PAUSE + i_start: go WAIT_LRC, o_address kept (resume, no reset to 0).
REQ-024 i_stop in any non-IDLE state: go IDLE next cycle; partial sample discarded; o_address holds last value (= sample count written).
REQ-025 Simultaneous pulses: priority i_stop > i_pause > i_start.
REQ-026 i_start while WAIT_LRC/SHIFT/WRITE SHALL be ignored; i_pause in IDLE/PAUSE ignored.
REQ-027 o_address SHALL never wrap past MAX_ADDR.

Reset
REQ-028 On i_rst_n low, immediately: state IDLE, o_address 0, o_data 0, o_wr 0, o_busy 0, o_full 0, lrc_d 1, bit counter 0.
REQ-029 Reset mid-SHIFT/WRITE SHALL suppress any pending o_wr.

Structure
REQ-030 State enum, SAMPLE_W=16, ADDR_W=20 SHALL live in shared package aud_pkg.
REQ-031 Single module, no sub-module; serial-to-parallel shifter inline.

Verification
REQ-032 Start, feed left sample 16'hA5C3 with one-bit delay -> o_wr one cycle after LSB, o_data 16'hA5C3, o_address 0.
REQ-033 Three consecutive frames 16'h0001,16'h8000,16'hFFFF, right channel 16'h1234 -> three o_wr at addresses 0,1,2, right data never written.
REQ-034 Pause at SHIFT bit 8, later i_start -> no o_wr for partial, next full sample written at address following last written.
REQ-035 MAX_ADDR=3, run 5 frames -> writes at 0..3, o_full=1, IDLE, no 5th o_wr; new i_start clears o_full, address 0.
REQ-036 i_stop and i_pause same cycle in SHIFT -> IDLE, o_busy 0, no o_wr.
REQ-037 Assert i_rst_n low during WRITE-preceding bit 15 -> all outputs 0 immediately, no o_wr after release.
